// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: core store port, memory drain port and load-forwarding probe.
// The buffer takes the slave side; the core/memory environment takes the master side.
interface store_buffer_if #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
);
    logic            st_valid;
    logic            st_ready;
    logic [AW-1:0]   st_addr;
    logic [DW-1:0]   st_data;
    logic [DW/8-1:0] st_mask;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wmask;

    logic [AW-1:0]   ld_addr;
    logic            ld_hit;
    logic            ld_partial;
    logic [DW-1:0]   ld_data;

    modport slave (
        input  st_valid, st_addr, st_data, st_mask, mem_req_ready, ld_addr,
        output st_ready, mem_req_valid, mem_addr, mem_wdata, mem_wmask,
        output ld_hit, ld_partial, ld_data
    );

    modport master (
        output st_valid, st_addr, st_data, st_mask, mem_req_ready, ld_addr,
        input  st_ready, mem_req_valid, mem_addr, mem_wdata, mem_wmask,
        input  ld_hit, ld_partial, ld_data
    );
endinterface

// File: rtl/store_buffer.sv
// In-order store FIFO between the core and data memory, with youngest-match
// store-to-load forwarding over the occupied entries.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 64,
    parameter int unsigned DW    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    store_buffer_if.slave          bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned MW = DW / 8;
    localparam int unsigned TW = AW - 3;

    typedef logic [IW:0] ptr_t;

    logic [TW-1:0] tag_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [MW-1:0] mask_q [DEPTH];

    ptr_t head_q, head_d, tail_q, tail_d;
    logic full, enq, deq;

    logic          fwd_found;
    logic [IW-1:0] fwd_idx;
    ptr_t          probe;
    logic          fwd_full_mask;
    logic          unused_low_bits;

    assign empty = (head_q == tail_q);
    assign full  = (head_q[IW] != tail_q[IW]) && (head_q[IW-1:0] == tail_q[IW-1:0]);
    assign count = tail_q - head_q;

    assign enq = bus.st_valid && !full;
    assign deq = bus.mem_req_ready && !empty;

    assign bus.st_ready      = !full;
    assign bus.mem_req_valid = !empty;
    assign bus.mem_addr      = {tag_q[head_q[IW-1:0]], 3'b000};
    assign bus.mem_wdata     = data_q[head_q[IW-1:0]];
    assign bus.mem_wmask     = mask_q[head_q[IW-1:0]];

    // Byte offsets are irrelevant at doubleword granularity.
    assign unused_low_bits = ^{bus.st_addr[2:0], bus.ld_addr[2:0]};

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (enq) tail_d = tail_q + ptr_t'(1);
        if (deq) head_d = head_q + ptr_t'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            tag_q[tail_q[IW-1:0]]  <= bus.st_addr[AW-1:3];
            data_q[tail_q[IW-1:0]] <= bus.st_data;
            mask_q[tail_q[IW-1:0]] <= bus.st_mask;
        end
    end

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        fwd_found = 1'b0;
        fwd_idx   = '0;
        probe     = head_q;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            probe = head_q + ptr_t'(k);
            if ((ptr_t'(k) < count) && (tag_q[probe[IW-1:0]] == bus.ld_addr[AW-1:3])) begin
                fwd_found = 1'b1;
                fwd_idx   = probe[IW-1:0];
            end
        end
    end

    assign fwd_full_mask  = &mask_q[fwd_idx];
    assign bus.ld_hit     = fwd_found && fwd_full_mask;
    assign bus.ld_partial = fwd_found && !fwd_full_mask;
    assign bus.ld_data    = bus.ld_hit ? data_q[fwd_idx] : '0;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: stores push expected memory writes into a
// scoreboard queue that an independent monitor pops on every memory handshake.
module tb_store_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count;
    logic       empty;

    always #5 clk = ~clk;

    store_buffer_if #(.AW(64), .DW(64)) bus ();

    store_buffer #(.DEPTH(4), .AW(64), .DW(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count),
        .empty (empty)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } wr_t;

    wr_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;
    int  mcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                         input bit accept);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_mask  = m;
        tick();
        bus.st_valid = 1'b0;
        if (accept) exp_q.push_back(wr_t'{addr: {a[63:3], 3'b000}, data: d, mask: m});
    endtask

    task automatic drain();
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !empty; i++) tick();
        chk("drain_empty", 64'(empty), 64'd1);
    endtask

    // Scoreboard monitor: a handshake seen at negedge completes at the next posedge.
    wr_t e;
    always @(negedge clk) begin
        if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL mem_unexpected: got write to %h, required no write", bus.mem_addr);
            end else begin
                e = exp_q.pop_front();
                chk("mem_addr", bus.mem_addr, e.addr);
                chk("mem_wdata", bus.mem_wdata, e.data);
                chk("mem_wmask", 64'(bus.mem_wmask), 64'(e.mask));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst               = 1'b1;
        bus.st_valid      = 1'b0;
        bus.st_addr       = '0;
        bus.st_data       = '0;
        bus.st_mask       = '0;
        bus.mem_req_ready = 1'b0;
        bus.ld_addr       = 64'h8000_1000;
        tick();
        tick();
        chk("rst_st_ready", 64'(bus.st_ready), 64'd1);
        chk("rst_mem_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ld_hit", 64'(bus.ld_hit), 64'd0);
        chk("rst_ld_partial", 64'(bus.ld_partial), 64'd0);
        chk("rst_ld_data", bus.ld_data, 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_empty", 64'(empty), 64'd1);

        // Single store, one cycle to the memory port, drained the next edge.
        bus.mem_req_ready = 1'b1;
        store(64'h8000_1000, 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        chk("t1_mem_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("t1_count", 64'(count), 64'd1);
        tick();
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_mem_valid_off", 64'(bus.mem_req_valid), 64'd0);

        // Fill, reject a fifth store, then drain in order.
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            store(64'h8000_0000 + 64'(8 * i), 64'hA000_0000_0000_0000 + 64'(i), 8'hFF, 1'b1);
        chk("t2_count_full", 64'(count), 64'd4);
        chk("t2_st_ready_full", 64'(bus.st_ready), 64'd0);
        store(64'h8000_0020, 64'hDEAD, 8'hFF, 1'b0);
        chk("t2_count_ignored", 64'(count), 64'd4);
        bus.mem_req_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("t2_drain_count", 64'(count), 64'(4 - j));
            if (j < 4) tick();
        end
        chk("t2_empty", 64'(empty), 64'd1);

        // Forwarding: youngest full-mask match, then a partial younger store.
        bus.mem_req_ready = 1'b0;
        store(64'h8000_2000, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1);
        store(64'h8000_2000, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b1);
        bus.ld_addr = 64'h8000_2004;
        #1;
        chk("t3_ld_hit", 64'(bus.ld_hit), 64'd1);
        chk("t3_ld_partial", 64'(bus.ld_partial), 64'd0);
        chk("t3_ld_data", bus.ld_data, 64'hBBBB_BBBB_BBBB_BBBB);
        store(64'h8000_2000, 64'hCCCC_CCCC_CCCC_CCCC, 8'h0F, 1'b1);
        #1;
        chk("t3_partial", 64'(bus.ld_partial), 64'd1);
        chk("t3_partial_hit", 64'(bus.ld_hit), 64'd0);
        chk("t3_partial_data", bus.ld_data, 64'd0);
        bus.ld_addr = 64'h8000_3000;
        #1;
        chk("t3_miss_hit", 64'(bus.ld_hit), 64'd0);
        chk("t3_miss_partial", 64'(bus.ld_partial), 64'd0);
        drain();

        // Full with store+dequeue in one cycle: only the dequeue happens.
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            store(64'h8000_4000 + 64'(8 * i), 64'hB000_0000_0000_0000 + 64'(i), 8'hFF, 1'b1);
        chk("t4_st_ready_full", 64'(bus.st_ready), 64'd0);
        bus.mem_req_ready = 1'b1;
        store(64'h8000_4100, 64'hBAD, 8'hFF, 1'b0);
        chk("t4_count_deq_only", 64'(count), 64'd3);
        chk("t4_st_ready", 64'(bus.st_ready), 64'd1);
        store(64'h8000_4200, 64'h600D, 8'hFF, 1'b1);
        chk("t4_count_enq_deq", 64'(count), 64'd3);
        drain();

        // Ten stores with random ready across pointer wrap; bench tracks occupancy.
        mcnt = 0;
        for (int i = 0; i < 10; i++) begin
            bit   acc;
            bit   rdy;
            logic [63:0] a;
            logic [63:0] d;
            logic [7:0]  m;
            a = 64'h8000_5003 + 64'(16 * i);
            d = 64'hC0DE_0000_0000_0000 + 64'(i);
            m = 8'hFF >> (i % 4);
            acc = 1'b0;
            for (int g = 0; g < 50 && !acc; g++) begin
                rdy               = 1'($urandom_range(0, 1));
                bus.mem_req_ready = rdy;
                bus.st_valid      = 1'b1;
                bus.st_addr       = a;
                bus.st_data       = d;
                bus.st_mask       = m;
                acc = (mcnt < 4);
                if (rdy && mcnt > 0) mcnt--;
                tick();
                if (acc) begin
                    mcnt++;
                    exp_q.push_back(wr_t'{addr: {a[63:3], 3'b000}, data: d, mask: m});
                end
            end
            bus.st_valid = 1'b0;
        end
        chk("t5_count_model", 64'(count), 64'(mcnt));
        drain();

        // Reset with entries queued discards them and issues no request.
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            store(64'h8000_6000 + 64'(8 * i), 64'hD000_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
        chk("t6_count", 64'(count), 64'd3);
        bus.ld_addr = 64'h8000_6008;
        #1;
        chk("t6_hit_before", 64'(bus.ld_hit), 64'd1);
        rst               = 1'b1;
        bus.mem_req_ready = 1'b1;
        tick();
        rst               = 1'b0;
        bus.mem_req_ready = 1'b0;
        chk("t6_empty", 64'(empty), 64'd1);
        chk("t6_count_zero", 64'(count), 64'd0);
        chk("t6_mem_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("t6_ld_hit", 64'(bus.ld_hit), 64'd0);
        tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
